// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//   Run-time controller for the clock-division prescaler. Counts clk_in cycles
//   against a divisor and emits a one-cycle clock-enable pulse (tick) every
//   cur_div+1 cycles, plus a 50% square wave (clk_out) that toggles on each
//   tick. Adds start/stop, single-step while stopped, and a valid/ready
//   handshake for reloading the divisor without disturbing the period that is
//   already in progress.
//
// Parameters
//   WIDTH        counter / divisor width in bits
//   DEFAULT_DIV  divisor in force after reset (tick period = div+1 cycles)
//   START_RUN    1: RUN after reset, 0: STOP after reset
//
// Ports
//   clk_in     in   system clock, everything on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   STOP -> RUN (ignored if stop is also high)
//   stop       in   RUN -> STOP (wins over start)
//   step       in   one tick while in STOP (start wins if both high)
//   cfg_div    in   new divisor value
//   cfg_valid  in   cfg_div valid
//   cfg_ready  out  controller can accept cfg_div (no reload pending)
//   tick       out  one-cycle enable pulse per period (registered)
//   clk_out    out  toggles on every tick (registered, observation only)
//   running    out  1 while in RUN
//   cur_div    out  divisor currently in force
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 5000,
    parameter bit          START_RUN   = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             tick,
    output logic             clk_out,
    output logic             running,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] RST_DIV   = WIDTH'(DEFAULT_DIV);
    localparam state_e           RST_STATE = START_RUN ? ST_RUN : ST_STOP;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] cur_div_q,  cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_q,     pend_d;
    logic             tick_q,     tick_d;
    logic             clk_out_q,  clk_out_d;

    logic             cfg_accept;
    logic             terminal;

    // A reload can only be captured while nothing is pending, so capture and
    // apply never fight over pend on the same edge.
    assign cfg_accept = cfg_valid && !pend_q;

    // >= rather than == so a count left above a shrunken divisor still
    // terminates; it also means count never needs to pass cur_div, so the
    // +1 below cannot wrap even at the all-ones divisor.
    assign terminal = (count_q >= cur_div_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        clk_out_d  = clk_out_q;

        if (state_q == ST_RUN) begin
            // The counter keeps running on the edge that samples stop; the
            // state change takes effect from the following cycle.
            if (stop) begin
                state_d = ST_STOP;
            end
            if (terminal) begin
                count_d   = '0;
                tick_d    = 1'b1;
                clk_out_d = ~clk_out_q;
                // Reloads land only on a period boundary, so the period in
                // progress always completes with the old divisor.
                if (pend_q) begin
                    cur_div_d = pend_div_q;
                    pend_d    = 1'b0;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            // STOP: count holds so that start resumes mid-period.
            if (start && !stop) begin
                state_d = ST_RUN;
            end else if (step) begin
                count_d   = '0;
                tick_d    = 1'b1;
                clk_out_d = ~clk_out_q;
            end
            // No period is in flight while stopped, so a reload applies at
            // once and restarts the count.
            if (pend_q) begin
                cur_div_d = pend_div_q;
                pend_d    = 1'b0;
                count_d   = '0;
            end
        end

        if (cfg_accept) begin
            pend_div_d = cfg_div;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            count_q    <= '0;
            cur_div_q  <= RST_DIV;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            clk_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            clk_out_q  <= clk_out_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign tick      = tick_q;
    assign clk_out   = clk_out_q;
    assign running   = (state_q == ST_RUN);
    assign cur_div   = cur_div_q;

endmodule
